// File: rtl/wram_bus_responder.sv
// wram_bus_responder: 6502 work-RAM responder (2 KiB mirrored over $0000-$1FFF) with sprite OAM DMA.
// The OAM DMA engine is compiled in only when OAM_DMA_EN is defined.
module wram_bus_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH = 8,
  parameter int WRAM_AW = 11,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'h4014
) (
  input  logic                  phi2,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  R_W_n,
  input  logic [REG_WIDTH-1:0]  d_in,
  output logic [REG_WIDTH-1:0]  d_out,
  output logic                  d_oe,
  output logic                  rdy,
  output logic [7:0]            oam_addr,
  output logic [7:0]            oam_data,
  output logic                  oam_we,
  output logic                  dma_busy
);
  logic [REG_WIDTH-1:0] mem [2**WRAM_AW];
  logic [REG_WIDTH-1:0] d_out_q, d_out_d, rd_data;
  logic d_oe_q, d_oe_d;
  logic idle, wram_hit, rd_en, wr_en;
  logic [WRAM_AW-1:0] rd_addr;
  logic unused;
  assign wram_hit = A[ADDR_WIDTH-1:13] == '0;
  assign rd_en = idle && wram_hit && R_W_n;
  assign wr_en = idle && wram_hit && !R_W_n;
  assign rd_data = mem[rd_addr];
  assign d_out = d_out_q;
  assign d_oe = d_oe_q;
  always_comb begin
    d_oe_d = rd_en;
    d_out_d = rd_en ? rd_data : d_out_q;
  end
  // WRAM contents deliberately survive reset
  always_ff @(posedge phi2)
    if (wr_en) mem[A[WRAM_AW-1:0]] <= d_in;
  always_ff @(posedge phi2 or negedge reset_n)
    if (!reset_n) begin
      d_out_q <= '0;
      d_oe_q <= 1'b0;
    end else begin
      d_out_q <= d_out_d;
      d_oe_q <= d_oe_d;
    end
`ifdef OAM_DMA_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} state_t;
  state_t state_q;
  logic cyc_odd_q, align_q, rdy_q, busy_q, oam_we_q, trig;
  logic [4:0] page_q;
  logic [7:0] idx_q, oam_addr_q, oam_data_q;
  assign idle = state_q == IDLE;
  assign trig = idle && !R_W_n && A == DMA_REG_ADDR && d_in[7:5] == 3'b000;
  assign rd_addr = idle ? A[WRAM_AW-1:0] : WRAM_AW'({page_q, idx_q});
  assign rdy = rdy_q;
  assign dma_busy = busy_q;
  assign oam_we = oam_we_q;
  assign oam_addr = oam_addr_q;
  assign oam_data = oam_data_q;
  assign unused = ^A[12:WRAM_AW];
  always_ff @(posedge phi2 or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cyc_odd_q <= 1'b0;
      align_q <= 1'b0;
      page_q <= '0;
      idx_q <= '0;
      rdy_q <= 1'b1;
      busy_q <= 1'b0;
      oam_we_q <= 1'b0;
      oam_addr_q <= '0;
      oam_data_q <= '0;
    end else begin
      cyc_odd_q <= !cyc_odd_q;
      case (state_q)
        IDLE: if (trig) begin
          state_q <= HALT;
          page_q <= d_in[4:0];
          align_q <= cyc_odd_q;
          idx_q <= '0;
          rdy_q <= 1'b0;
          busy_q <= 1'b1;
        end
        HALT: state_q <= align_q ? ALIGN : RD;
        ALIGN: state_q <= RD;
        // outputs are registered, so the WR cycle's strobe is set up on the RD edge
        RD: begin
          state_q <= WR;
          oam_we_q <= 1'b1;
          oam_addr_q <= idx_q;
          oam_data_q <= rd_data;
        end
        WR: begin
          oam_we_q <= 1'b0;
          idx_q <= idx_q + 8'd1;
          if (idx_q == 8'hFF) begin
            state_q <= IDLE;
            rdy_q <= 1'b1;
            busy_q <= 1'b0;
          end else state_q <= RD;
        end
        default: state_q <= IDLE;
      endcase
    end
`else
  assign idle = 1'b1;
  assign rd_addr = A[WRAM_AW-1:0];
  assign rdy = 1'b1;
  assign dma_busy = 1'b0;
  assign oam_we = 1'b0;
  assign oam_addr = '0;
  assign oam_data = '0;
  assign unused = ^{A[12:WRAM_AW], DMA_REG_ADDR};
`endif
endmodule
